// File: rtl/multi_dataflow_job_ctrl.sv
// Job sequencer for the single-FIR multi-dataflow network: it latches a job, gates
// exactly len samples into the network and forwards len results to the sink.
module multi_dataflow_job_ctrl #(
    parameter int CNT_W   = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  len,
    input  logic [31:0]       coeff_in_0,
    input  logic [31:0]       coeff_in_1,
    input  logic [31:0]       coeff_in_2,
    input  logic [31:0]       coeff_in_3,
    output logic [31:0]       coeff_0_V,
    output logic [31:0]       coeff_1_V,
    output logic [31:0]       coeff_2_V,
    output logic [31:0]       coeff_3_V,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [DATA_W-1:0] net_in_data,
    output logic              net_in_wr,
    input  logic              net_in_full,
    input  logic [DATA_W-1:0] net_out_data,
    input  logic              net_out_wr,
    output logic              net_out_full,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_valid,
    input  logic              dst_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [CNT_W-1:0]  out_cnt
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [3:0][31:0]    coeff_q, coeff_d;
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                err_q, err_d;

    logic                in_run;
    logic                fwd_active;
    logic                in_fire;
    logic                out_fire;
    logic                in_last;
    logic                out_last;

    // Handshakes are pure functions of registered state and the peer's flag,
    // so the data path adds no latency.
    assign in_run       = (state_q == S_RUN);
    assign fwd_active   = (state_q == S_RUN) || (state_q == S_DRAIN);

    assign src_ready    = in_run && !net_in_full && (in_cnt_q < len_q);
    assign net_in_wr    = src_valid && src_ready;
    assign net_in_data  = src_data;

    assign dst_data     = net_out_data;
    assign dst_valid    = fwd_active && net_out_wr;
    assign net_out_full = fwd_active && !dst_ready;

    assign in_fire      = net_in_wr;
    assign out_fire     = dst_valid && dst_ready;
    assign in_last      = in_fire  && ((in_cnt_q  + CNT_W'(1)) == len_q);
    assign out_last     = out_fire && ((out_cnt_q + CNT_W'(1)) == len_q);

    assign coeff_0_V    = coeff_q[0];
    assign coeff_1_V    = coeff_q[1];
    assign coeff_2_V    = coeff_q[2];
    assign coeff_3_V    = coeff_q[3];

    assign busy         = (state_q == S_LOAD) || fwd_active;
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign in_cnt       = in_cnt_q;
    assign out_cnt      = out_cnt_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        coeff_d   = coeff_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        idle_d    = '0;
        err_d     = err_q;

        if (in_fire) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        if (out_fire) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    err_d     = 1'b0;
                    if (len != '0) begin
                        len_d   = len;
                        coeff_d = {coeff_in_3, coeff_in_2, coeff_in_1, coeff_in_0};
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            // Abort wins over completion, but the coinciding transfer is still counted above.
            S_RUN: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (out_last) begin
                    state_d = S_DONE;
                end else if (in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (out_last) begin
                    state_d = S_DONE;
                end else if (!out_fire) begin
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            coeff_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            idle_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            coeff_q   <= coeff_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            idle_q    <= idle_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: doc/multi_dataflow_job_ctrl.md
# multi_dataflow_job_ctrl

Job sequencer for the single-FIR multi-dataflow network. It latches a coefficient set and a job length on `start`, then drives the coefficient ports stable for the whole job. It gates exactly `len` samples from a valid/ready source into the network input stream and forwards network outputs to a valid/ready sink until `len` results have been delivered. It sits between the HWPE streamer/register file and `multi_dataflow`, replacing direct wiring of the stream and coefficient ports.

## Interface
- `CNT_W`, 16: width of job length and counters.
- `DATA_W`, 32: stream data width.
- `TIMEOUT`, 1024: maximum idle cycles in DRAIN before abandoning the job.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: job start pulse; honoured only in IDLE.
- `abort` in 1: cancel current job.
- `len` in CNT_W: samples per job; sampled with `start`.
- `coeff_in_0`..`coeff_in_3` in 32 each: coefficient set; sampled with `start`.
- `coeff_0_V`..`coeff_3_V` out 32 each: registered coefficients to the network.
- `src_data` in DATA_W, `src_valid` in 1, `src_ready` out 1: sample source.
- `net_in_data` out DATA_W, `net_in_wr` out 1, `net_in_full` in 1: network input stream. A word is written when `net_in_wr` is 1.
- `net_out_data` in DATA_W, `net_out_wr` in 1, `net_out_full` out 1: network output stream. A word transfers when `net_out_wr`=1 and `net_out_full`=0.
- `dst_data` out DATA_W, `dst_valid` out 1, `dst_ready` in 1: result sink.
- `busy` out 1: high in LOAD, RUN, DRAIN.
- `done` out 1: one-cycle pulse at job end.
- `err` out 1: last job ended by timeout or abort; sticky until next accepted `start`.
- `in_cnt` out CNT_W: samples sent this job.
- `out_cnt` out CNT_W: results delivered this job.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- **IDLE**
  - `start`=1 and `len`≠0: latch `len` and coefficients, clear `in_cnt`, `out_cnt` and `err`, go to LOAD.
  - `start`=1 and `len`=0: clear counters and `err`, go to DONE. Coefficients are not updated.
- **LOAD**: one cycle so coefficients settle in the network. Then go to RUN.
- **RUN**
  - `src_ready` = !`net_in_full` && `in_cnt` < `len_q`.
  - `net_in_wr` = `src_valid` && `src_ready`.
  - `net_in_data` = `src_data`.
  - Each write increments `in_cnt`. When `in_cnt` reaches `len_q`, go to DRAIN. Outputs are forwarded in RUN as well.
- **Output path** (RUN and DRAIN): combinational pass-through.
  - `dst_data` = `net_out_data`.
  - `dst_valid` = `net_out_wr`.
  - `net_out_full` = !`dst_ready`.
  - Each transfer increments `out_cnt`.
  - The transfer that makes `out_cnt` equal `len_q` moves the FSM to DONE, from either RUN or DRAIN.
- **DRAIN**
  - `src_ready`=0.
  - Idle counter counts cycles without an output transfer and clears on each transfer.
  - Reaching `TIMEOUT` sets `err` and moves to DONE.
- **DONE**: `done`=1 for one cycle, then go to IDLE. Counters hold their values until the next accepted `start`.
- **Outside RUN/DRAIN**:
  - `net_out_full`=0 and `dst_valid`=0, so stray network outputs are consumed and discarded without being counted.
  - `net_in_wr`=0 and `src_ready`=0.
- **abort** in LOAD/RUN/DRAIN: set `err` and go to DONE. Abort is ignored in IDLE and DONE.
- **Simultaneous events**: abort takes priority over a completing transfer; that transfer still completes and is counted.
- `start` while not in IDLE is ignored. It is not queued.
- Counters saturate at `len_q` by construction; no wrap-around.

## Timing
- Reset values:
  - state IDLE.
  - All `coeff_*_V`, `in_cnt`, `out_cnt`, and the idle counter = 0.
  - `busy`, `done`, `err` = 0.
  - `src_ready`=0, `net_in_wr`=0, `dst_valid`=0, `net_out_full`=0.
- Reset asserted mid-job returns to IDLE immediately. No `done` pulse is produced and in-flight network data is not tracked.
- `start` at cycle 0:
  - LOAD at cycle 1 (`busy`=1).
  - Coefficients visible on `coeff_*_V` from cycle 1.
  - RUN from cycle 2; first sample can be accepted at cycle 2.
- `done` asserts the cycle after the final output transfer, abort, or timeout.
- With `len`=0, `done` asserts at cycle 1.
- `coeff_*_V` change only on an accepted `start` with nonzero `len`.
- All state, counters and `coeff_*_V` are registered.
- `src_ready`, `net_in_wr`, `dst_valid` and `net_out_full` are combinational from registered state and their respective handshake inputs. There is no extra latency on the data path.

## Test plan
- **Basic job**: coeffs 1,0,0,0, `len`=4, source 10,20,30,40 with sink always ready.
  - 4 writes to the network starting at cycle 2.
  - Sink receives the network's 4 results.
  - `done` one cycle after the 4th result; `in_cnt`=`out_cnt`=4; `err`=0.
- **Backpressure**: toggle `net_in_full` and `dst_ready` pseudo-randomly with `len`=16.
  - No write while `net_in_full`=1.
  - No sink transfer while `dst_ready`=0.
  - Exactly 16 in and 16 out; single `done` pulse.
- **Zero length**: `start` with `len`=0.
  - `done` at cycle 1, `busy` never high.
  - `coeff_*_V` keep their previous values.
- **Timeout**: `len`=4, network withholds outputs after 2 results, `TIMEOUT`=8.
  - `done` and `err`=1 eight cycles into DRAIN without a transfer.
  - `out_cnt`=2.
- **Ignored start / abort**:
  - `start` with new coeffs during RUN: coefficients unchanged.
  - `abort` during RUN: `done` next cycle, `err`=1, `src_ready`=0 from the DONE cycle.
- **Reset mid-job**: assert `reset` during DRAIN.
  - All outputs at reset values immediately, no `done` pulse.
  - A subsequent job with `len`=2 completes normally.
